// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: write-back owns the port combinationally,
// buffered MDU results drain into idle cycles, with starvation stall and WAW squash.
module wb_port_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  wb_waddr_i,
  input  logic        wb_wena_i,
  input  logic [31:0] wb_wdata_i,
  input  logic        mdu_valid_i,
  output logic        mdu_ready_o,
  input  logic [4:0]  mdu_waddr_i,
  input  logic [31:0] mdu_wdata_i,
  output logic        stall_o,
  output logic [4:0]  rf_waddr_o,
  output logic        rf_wena_o,
  output logic [31:0] rf_wdata_o,
  output logic        pending_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [WW-1:0] MAX_WAIT_C = WW'(MAX_WAIT);

  logic [4:0]       addr_mem [DEPTH];
  logic [31:0]      data_mem [DEPTH];
  logic [DEPTH-1:0] live_reg, live_next;
  logic [PW-1:0]    rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0]    count_reg, count_next;
  logic [WW-1:0]    wait_reg, wait_next;

  logic wbreq, deq, enq;
  logic [4:0]  head_addr;
  logic [31:0] head_data;
  logic        head_live;

  assign pending_o   = !rst && (count_reg != '0);
  assign stall_o     = pending_o && (wait_reg == MAX_WAIT_C);
  assign mdu_ready_o = !rst && (count_reg < DEPTH_C);

  // A stalled write-back is ignored entirely, so the head always wins that cycle.
  assign wbreq = !rst && wb_wena_i && (wb_waddr_i != 5'd0) && !stall_o;
  assign deq   = pending_o && !wbreq;
  assign enq   = mdu_valid_i && mdu_ready_o;

  assign head_addr = addr_mem[rd_ptr_reg];
  assign head_data = data_mem[rd_ptr_reg];
  assign head_live = live_reg[rd_ptr_reg];

  always_comb begin
    rf_wena_o  = 1'b0;
    rf_waddr_o = 5'd0;
    rf_wdata_o = 32'd0;
    if (wbreq) begin
      rf_wena_o  = 1'b1;
      rf_waddr_o = wb_waddr_i;
      rf_wdata_o = wb_wdata_i;
    end else if (deq) begin
      rf_wena_o  = head_live;
      rf_waddr_o = head_addr;
      rf_wdata_o = head_data;
    end
  end

  // Enqueue into the write slot beats squash; that slot never holds a stored entry.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_live
      assign live_next[gi] = (enq && (wr_ptr_reg == PW'(gi))) ? (mdu_waddr_i != 5'd0)
                           : (live_reg[gi] && !(wbreq && (addr_mem[gi] == wb_waddr_i)));
    end
  endgenerate

  always_comb begin
    count_next = count_reg;
    case ({enq, deq})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_comb begin
    wait_next = wait_reg;
    if ((count_reg == '0) || deq)
      wait_next = '0;
    else if (wait_reg != MAX_WAIT_C)
      wait_next = wait_reg + WW'(1);
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem[wr_ptr_reg] <= mdu_waddr_i;
      data_mem[wr_ptr_reg] <= mdu_wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      live_reg   <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      wait_reg   <= '0;
    end else begin
      live_reg  <= live_next;
      count_reg <= count_next;
      wait_reg  <= wait_next;
      if (enq) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (deq) rd_ptr_reg <= rd_ptr_reg + PW'(1);
    end
  end

endmodule
